// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one cacheline adaptor between I-cache and D-cache, one whole line at a time.
// Define CACHELINE_ARBITER_RR_EN for round-robin tie-break; default is fixed D-cache priority.
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_read_i,
  input  logic [ADDR_W-1:0] ic_address_i,
  output logic [LINE_W-1:0] ic_line_o,
  output logic              ic_resp_o,
  input  logic              dc_read_i,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_address_i,
  input  logic [LINE_W-1:0] dc_line_i,
  output logic [LINE_W-1:0] dc_line_o,
  output logic              dc_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [LINE_W-1:0] mem_line_o,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_resp_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic gnt_dc;
  logic dc_req;
  logic pick_dc;
  assign dc_req = dc_read_i | dc_write_i;
`ifdef CACHELINE_ARBITER_RR_EN
  logic last_dc;
  assign pick_dc = dc_req & (~ic_read_i | ~last_dc);
`else
  assign pick_dc = dc_req;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gnt_dc        <= 1'b0;
      ic_line_o     <= '0;
      dc_line_o     <= '0;
      ic_resp_o     <= 1'b0;
      dc_resp_o     <= 1'b0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_address_o <= '0;
      mem_line_o    <= '0;
`ifdef CACHELINE_ARBITER_RR_EN
      last_dc       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (ic_read_i | dc_req) begin
          gnt_dc        <= pick_dc;
          mem_address_o <= pick_dc ? dc_address_i : ic_address_i;
          mem_write_o   <= pick_dc & dc_write_i;
          mem_read_o    <= ~(pick_dc & dc_write_i);
          if (pick_dc) mem_line_o <= dc_line_i;
          state         <= ACCESS;
        end
        ACCESS: if (mem_resp_i) begin
          // write-backs leave the returned-line registers untouched
          if (mem_read_o && gnt_dc) dc_line_o <= mem_line_i;
          if (mem_read_o && !gnt_dc) ic_line_o <= mem_line_i;
          mem_read_o  <= 1'b0;
          mem_write_o <= 1'b0;
          ic_resp_o   <= ~gnt_dc;
          dc_resp_o   <= gnt_dc;
          state       <= RESP;
        end
        RESP: begin
          ic_resp_o <= 1'b0;
          dc_resp_o <= 1'b0;
`ifdef CACHELINE_ARBITER_RR_EN
          last_dc   <= gnt_dc;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: randomized self-checking bench with a transaction-level arbitration model.
module tb_cacheline_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ic_read_i = 1'b0, dc_read_i = 1'b0, dc_write_i = 1'b0, mem_resp_i = 1'b0;
  logic [AW-1:0] ic_address_i = '0, dc_address_i = '0;
  logic [LW-1:0] dc_line_i = '0, mem_line_i = '0;
  logic [LW-1:0] ic_line_o, dc_line_o, mem_line_o;
  logic [AW-1:0] mem_address_o;
  logic ic_resp_o, dc_resp_o, mem_read_o, mem_write_o;
  int checks = 0;
  int errors = 0;
  logic last_dc = 1'b1;
  logic [LW-1:0] ic_seen = '0, dc_seen = '0;

  cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_read_i(ic_read_i), .ic_address_i(ic_address_i), .ic_line_o(ic_line_o), .ic_resp_o(ic_resp_o),
    .dc_read_i(dc_read_i), .dc_write_i(dc_write_i), .dc_address_i(dc_address_i),
    .dc_line_i(dc_line_i), .dc_line_o(dc_line_o), .dc_resp_o(dc_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
    .mem_line_o(mem_line_o), .mem_line_i(mem_line_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Tie-break rule: a lone requester always wins; ties go by configuration.
  function automatic logic win_dc(input logic ic, input logic dc);
`ifdef CACHELINE_ARBITER_RR_EN
    return dc && (!ic || !last_dc);
`else
    return dc;
`endif
  endfunction

  function automatic logic all_zero();
    return {ic_resp_o, dc_resp_o, mem_read_o, mem_write_o} === 4'b0 && mem_address_o === '0 &&
           mem_line_o === '0 && ic_line_o === '0 && dc_line_o === '0;
  endfunction

  // Drives one transaction from IDLE, plays the adaptor with a fixed latency, checks every cycle.
  task automatic run_txn(input logic ic_rd, input logic dc_rd, input logic dc_wr,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da, input logic [LW-1:0] dl,
                         input logic [LW-1:0] rl, input int lat, input logic scramble, input string tag);
    logic wdc, wr;
    logic [AW-1:0] ea;
    ic_read_i = ic_rd; dc_read_i = dc_rd; dc_write_i = dc_wr;
    ic_address_i = ia; dc_address_i = da; dc_line_i = dl;
    wdc = win_dc(ic_rd, dc_rd | dc_wr);
    wr = wdc && dc_wr;
    ea = wdc ? da : ia;
    for (int c = 0; c < lat; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({mem_read_o, mem_write_o, mem_address_o} !== {!wr, wr, ea} || (wr && mem_line_o !== dl) ||
          ic_resp_o !== 1'b0 || dc_resp_o !== 1'b0) begin
        errors++;
        $display("FAIL %s access cyc%0d: rd=%b wr=%b addr=%h resp=%b%b, required rd=%b wr=%b addr=%h resp=00",
                 tag, c, mem_read_o, mem_write_o, mem_address_o, ic_resp_o, dc_resp_o, !wr, wr, ea);
      end
      if (scramble && c == 0) begin
        dc_address_i = 32'hDEAD_BEE0;
        ic_address_i = 32'hDEAD_BEE0;
        dc_line_i = ~dl;
      end
    end
    mem_resp_i = 1'b1;
    mem_line_i = rl;
    @(posedge clk); #1;
    mem_resp_i = 1'b0;
    mem_line_i = rand_line();
    if (!wr && wdc) dc_seen = rl;
    if (!wr && !wdc) ic_seen = rl;
    checks++;
    if ({ic_resp_o, dc_resp_o, mem_read_o, mem_write_o} !== {!wdc, wdc, 2'b00} ||
        ic_line_o !== ic_seen || dc_line_o !== dc_seen) begin
      errors++;
      $display("FAIL %s resp: ic_resp=%b dc_resp=%b rd=%b wr=%b ic_line=%h dc_line=%h, required %b %b 0 0 ic_line=%h dc_line=%h",
               tag, ic_resp_o, dc_resp_o, mem_read_o, mem_write_o, ic_line_o[63:0], dc_line_o[63:0],
               !wdc, wdc, ic_seen[63:0], dc_seen[63:0]);
    end
    last_dc = wdc;
    if (wdc) {dc_read_i, dc_write_i} = 2'b00;
    else ic_read_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ic_resp_o, dc_resp_o, mem_read_o, mem_write_o} !== 4'b0) begin
      errors++;
      $display("FAIL %s after-resp: resp=%b%b rd=%b wr=%b, required all 0",
               tag, ic_resp_o, dc_resp_o, mem_read_o, mem_write_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL reset_held: resp=%b%b rd=%b wr=%b addr=%h, required all 0",
               ic_resp_o, dc_resp_o, mem_read_o, mem_write_o, mem_address_o);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL reset_release: resp=%b%b rd=%b wr=%b addr=%h, required all 0",
               ic_resp_o, dc_resp_o, mem_read_o, mem_write_o, mem_address_o);
    end
  endtask

  task automatic test_tie();
    for (int r = 0; r < 3; r++)
      run_txn(1'b1, 1'b1, 1'b0, 32'h0000_2000 + r * 32'h40, 32'h0000_3000 + r * 32'h40,
              '0, rand_line(), 3 + r, 1'b0, "tie");
    {ic_read_i, dc_read_i, dc_write_i} = 3'b000;
  endtask

  task automatic test_ic_read();
    logic [LW-1:0] a5;
    a5 = {(LW / 8){8'hA5}};
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0, a5, 12, 1'b0, "ic_read");
    checks++;
    if (ic_line_o !== a5) begin
      errors++;
      $display("FAIL ic_read_line: got %h required %h", ic_line_o[63:0], a5[63:0]);
    end
  endtask

  task automatic test_dc_write();
    run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0040, {4{64'h0123_4567_89AB_CDEF}},
            rand_line(), 6, 1'b0, "dc_write");
  endtask

  task automatic test_addr_change();
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_5540, '0, rand_line(), 5, 1'b1, "addr_change");
    run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_6680, rand_line(), rand_line(), 4, 1'b1, "data_change");
  endtask

  task automatic test_stray_resp();
    mem_resp_i = 1'b1;
    mem_line_i = rand_line();
    @(posedge clk); #1;
    mem_resp_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({ic_resp_o, dc_resp_o, mem_read_o, mem_write_o} !== 4'b0 ||
          ic_line_o !== ic_seen || dc_line_o !== dc_seen) begin
        errors++;
        $display("FAIL stray_resp cyc%0d: resp=%b%b rd=%b wr=%b, required all 0 and lines unchanged",
                 c, ic_resp_o, dc_resp_o, mem_read_o, mem_write_o);
      end
      @(posedge clk); #1;
    end
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h0, '0, rand_line(), 2, 1'b0, "after_stray");
  endtask

  task automatic test_async_reset();
    ic_read_i = 1'b1; ic_address_i = 32'h0000_9000;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL async_reset_now: rd=%b wr=%b addr=%h, required all 0", mem_read_o, mem_write_o, mem_address_o);
    end
    ic_read_i = 1'b0;
    last_dc = 1'b1; ic_seen = '0; dc_seen = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_resp_i = 1'b1;
    @(posedge clk); #1;
    mem_resp_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (!all_zero()) begin
        errors++;
        $display("FAIL async_reset_after cyc%0d: resp=%b%b rd=%b wr=%b, required all 0",
                 c, ic_resp_o, dc_resp_o, mem_read_o, mem_write_o);
      end
      @(posedge clk); #1;
    end
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_A0C0, '0, rand_line(), 4, 1'b0, "post_reset");
  endtask

  // Random traffic: pending requests stay held until served, as the caches would.
  task automatic test_random();
    logic ic_p, dc_p, dc_w;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] dl;
    ic_p = 1'b0; dc_p = 1'b0; dc_w = 1'b0; ia = '0; da = '0; dl = '0;
    for (int n = 0; n < 40; n++) begin
      if (!ic_p && $urandom_range(1, 0) == 1) begin ic_p = 1'b1; ia = $urandom & ~32'h1F; end
      if (!dc_p && $urandom_range(1, 0) == 1) begin
        dc_p = 1'b1; dc_w = $urandom_range(1, 0) == 1; da = $urandom & ~32'h1F; dl = rand_line();
      end
      if (!ic_p && !dc_p) begin ic_p = 1'b1; ia = $urandom & ~32'h1F; end
      run_txn(ic_p, dc_p && !dc_w, dc_p && dc_w, ia, da, dl, rand_line(),
              $urandom_range(6, 1), $urandom_range(1, 0) == 1, "random");
      if (last_dc) dc_p = 1'b0;
      else ic_p = 1'b0;
    end
    {ic_read_i, dc_read_i, dc_write_i} = 3'b000;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_ic_read();
    test_dc_write();
    test_addr_change();
    test_stray_resp();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
